// File: rtl/knn_topk_vote_pkg.sv
// rtl/knn_topk_vote_pkg.sv - shared state encoding and width helpers for the k-NN top-K voter
package knn_topk_vote_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_VOTE    = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int unsigned VARWIDTH_DEF    = 32;
  localparam int unsigned LABEL_WIDTH_DEF = 8;
  localparam int unsigned K_DEF           = 4;

  // Index width that stays legal (>=1 bit) even when only one slot exists.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/knn_topk_vote_if.sv
// rtl/knn_topk_vote_if.sv - distance stream handshake between the distance stage and the voter
interface knn_topk_vote_if #(
  parameter int VARWIDTH    = 32,
  parameter int LABEL_WIDTH = 8
);
  logic                   start;
  logic                   dist_valid;
  logic [VARWIDTH-1:0]    dist_in;
  logic [LABEL_WIDTH-1:0] label_in;
  logic                   last_in;
  logic                   ready;

  modport master (
    output start, dist_valid, dist_in, label_in, last_in,
    input  ready
  );

  modport slave (
    input  start, dist_valid, dist_in, label_in, last_in,
    output ready
  );
endinterface

// File: rtl/knn_topk_vote_slot.sv
// rtl/knn_topk_vote_slot.sv - one cell of the sorted nearest-neighbour list
module knn_topk_vote_slot
  import knn_topk_vote_pkg::*;
#(
  parameter int VARWIDTH    = VARWIDTH_DEF,
  parameter int LABEL_WIDTH = LABEL_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear_i,
  input  logic                   ins_i,
  input  logic [VARWIDTH-1:0]    dist_in_i,
  input  logic [LABEL_WIDTH-1:0] label_in_i,
  input  logic                   prev_le_i,
  input  logic                   prev_valid_i,
  input  logic [VARWIDTH-1:0]    prev_dist_i,
  input  logic [LABEL_WIDTH-1:0] prev_label_i,
  output logic                   le_o,
  output logic                   valid_o,
  output logic [VARWIDTH-1:0]    dist_o,
  output logic [LABEL_WIDTH-1:0] label_o
);

  logic                   valid_q, valid_d;
  logic [VARWIDTH-1:0]    dist_q,  dist_d;
  logic [LABEL_WIDTH-1:0] label_q, label_d;

  // le flags form a prefix over the list, so the first slot with le=0 is the insertion point.
  assign le_o = valid_q && (dist_q <= dist_in_i);

  always_comb begin
    valid_d = valid_q;
    dist_d  = dist_q;
    label_d = label_q;
    if (clear_i) begin
      valid_d = 1'b0;
      dist_d  = '0;
      label_d = '0;
    end else if (ins_i && !le_o) begin
      if (prev_le_i) begin
        valid_d = 1'b1;
        dist_d  = dist_in_i;
        label_d = label_in_i;
      end else begin
        valid_d = prev_valid_i;
        dist_d  = prev_dist_i;
        label_d = prev_label_i;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      dist_q  <= '0;
      label_q <= '0;
    end else begin
      valid_q <= valid_d;
      dist_q  <= dist_d;
      label_q <= label_d;
    end
  end

  assign valid_o = valid_q;
  assign dist_o  = dist_q;
  assign label_o = label_q;

endmodule

// File: rtl/knn_topk_vote.sv
// rtl/knn_topk_vote.sv - keeps the K nearest distances with labels and majority-votes a class
module knn_topk_vote
  import knn_topk_vote_pkg::*;
#(
  parameter int VARWIDTH    = VARWIDTH_DEF,
  parameter int LABEL_WIDTH = LABEL_WIDTH_DEF,
  parameter int K           = K_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  knn_topk_vote_if.slave             s_if,
  output logic [K*VARWIDTH-1:0]      knn_dist,
  output logic [K*LABEL_WIDTH-1:0]   knn_label,
  output logic [$clog2(K+1)-1:0]     knn_count,
  output logic [LABEL_WIDTH-1:0]     class_out,
  output logic                       done
);

  localparam int CNTW = $clog2(K + 1);
  localparam int CW   = idx_width(K);

  state_t                 state_q, state_d;
  logic [CNTW-1:0]        count_q, count_d;
  logic [CW-1:0]          cand_q, cand_d;
  logic [CNTW-1:0]        best_cnt_q, best_cnt_d;
  logic [LABEL_WIDTH-1:0] best_label_q, best_label_d;
  logic [LABEL_WIDTH-1:0] class_q, class_d;

  logic                   accept;
  logic [K-1:0]           le, valid;
  logic [K-1:0]           prev_le, prev_valid;
  logic [VARWIDTH-1:0]    dist_a [K];
  logic [LABEL_WIDTH-1:0] label_a [K];
  logic [VARWIDTH-1:0]    prev_dist [K];
  logic [LABEL_WIDTH-1:0] prev_label [K];

  // start has priority, so a strobe in the same cycle as start is never inserted.
  assign accept = (state_q == ST_COLLECT) && s_if.dist_valid && !s_if.start;

  for (genvar i = 0; i < K; i++) begin : g_slot
    if (i == 0) begin : g_head
      assign prev_le[i]    = 1'b1;
      assign prev_valid[i] = 1'b0;
      assign prev_dist[i]  = '0;
      assign prev_label[i] = '0;
    end else begin : g_body
      assign prev_le[i]    = le[i-1];
      assign prev_valid[i] = valid[i-1];
      assign prev_dist[i]  = dist_a[i-1];
      assign prev_label[i] = label_a[i-1];
    end

    knn_topk_vote_slot #(
      .VARWIDTH    (VARWIDTH),
      .LABEL_WIDTH (LABEL_WIDTH)
    ) u_slot (
      .clk          (clk),
      .rst          (rst),
      .clear_i      (s_if.start),
      .ins_i        (accept),
      .dist_in_i    (s_if.dist_in),
      .label_in_i   (s_if.label_in),
      .prev_le_i    (prev_le[i]),
      .prev_valid_i (prev_valid[i]),
      .prev_dist_i  (prev_dist[i]),
      .prev_label_i (prev_label[i]),
      .le_o         (le[i]),
      .valid_o      (valid[i]),
      .dist_o       (dist_a[i]),
      .label_o      (label_a[i])
    );

    assign knn_dist[i*VARWIDTH +: VARWIDTH]          = dist_a[i];
    assign knn_label[i*LABEL_WIDTH +: LABEL_WIDTH]   = label_a[i];
  end

  logic [LABEL_WIDTH-1:0] cand_label;
  logic                   cand_valid;
  logic [CNTW-1:0]        cand_cnt;
  logic                   cand_wins;

  always_comb begin
    cand_label = '0;
    cand_valid = 1'b0;
    for (int j = 0; j < K; j++) begin
      if (cand_q == CW'(j)) begin
        cand_label = label_a[j];
        cand_valid = valid[j];
      end
    end
    cand_cnt = '0;
    for (int j = 0; j < K; j++) begin
      if (valid[j] && (label_a[j] == cand_label)) cand_cnt = cand_cnt + CNTW'(1);
    end
    // Strict greater-than keeps the nearest slot on a tie.
    cand_wins = cand_valid && (cand_cnt > best_cnt_q);
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    cand_d       = cand_q;
    best_cnt_d   = best_cnt_q;
    best_label_d = best_label_q;
    class_d      = class_q;
    if (s_if.start) begin
      state_d      = ST_COLLECT;
      count_d      = '0;
      cand_d       = '0;
      best_cnt_d   = '0;
      best_label_d = '0;
      class_d      = '0;
    end else begin
      case (state_q)
        ST_COLLECT: begin
          if (s_if.dist_valid) begin
            if (count_q != CNTW'(K)) count_d = count_q + CNTW'(1);
            if (s_if.last_in) begin
              state_d      = ST_VOTE;
              cand_d       = '0;
              best_cnt_d   = '0;
              best_label_d = '0;
            end
          end
        end
        ST_VOTE: begin
          if (cand_wins) begin
            best_cnt_d   = cand_cnt;
            best_label_d = cand_label;
          end
          if (cand_q == CW'(K - 1)) begin
            state_d = ST_DONE;
            class_d = cand_wins ? cand_label : best_label_q;
          end else begin
            cand_d = cand_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      cand_q       <= '0;
      best_cnt_q   <= '0;
      best_label_q <= '0;
      class_q      <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      cand_q       <= cand_d;
      best_cnt_q   <= best_cnt_d;
      best_label_q <= best_label_d;
      class_q      <= class_d;
    end
  end

  assign s_if.ready = (state_q == ST_COLLECT);
  assign done       = (state_q == ST_DONE);
  assign knn_count  = count_q;
  assign class_out  = class_q;

endmodule

// File: tb/tb_knn_topk_vote.sv
// tb/tb_knn_topk_vote.sv - directed self-checking bench for knn_topk_vote (K=4)
module tb_knn_topk_vote;
  import knn_topk_vote_pkg::*;

  localparam int VW = 32;
  localparam int LW = 8;
  localparam int KK = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [KK*VW-1:0]  knn_dist;
  logic [KK*LW-1:0]  knn_label;
  logic [2:0]        knn_count;
  logic [LW-1:0]     class_out;
  logic              done;

  int passed = 0;
  int total  = 0;
  int lat;

  knn_topk_vote_if #(.VARWIDTH(VW), .LABEL_WIDTH(LW)) m_if ();

  knn_topk_vote #(.VARWIDTH(VW), .LABEL_WIDTH(LW), .K(KK)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_if      (m_if.slave),
    .knn_dist  (knn_dist),
    .knn_label (knn_label),
    .knn_count (knn_count),
    .class_out (class_out),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  // Tasks enter and leave on a falling edge; inputs settle half a cycle before the rising edge.
  task automatic pulse_start();
    m_if.start = 1'b1;
    @(negedge clk);
    m_if.start = 1'b0;
  endtask

  task automatic strobe(input logic [31:0] d, input logic [7:0] l, input logic last);
    m_if.dist_valid = 1'b1;
    m_if.dist_in    = d;
    m_if.label_in   = l;
    m_if.last_in    = last;
    @(negedge clk);
    m_if.dist_valid = 1'b0;
    m_if.last_in    = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    m_if.start      = 1'b0;
    m_if.dist_valid = 1'b0;
    m_if.dist_in    = '0;
    m_if.label_in   = '0;
    m_if.last_in    = 1'b0;

    #3;
    check("rst_done",  done, 0);
    check("rst_ready", m_if.ready, 0);
    check("rst_count", knn_count, 0);
    check("rst_dist",  knn_dist, 0);
    check("rst_class", class_out, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 1: sort and drop
    pulse_start();
    check("t1_ready", m_if.ready, 1);
    strobe(50, 1, 0);
    strobe(20, 2, 0);
    strobe(80, 3, 0);
    strobe(10, 4, 0);
    strobe(30, 5, 1);
    check("t1_dist",  knn_dist, {32'd50, 32'd30, 32'd20, 32'd10});
    check("t1_label", knn_label, {8'd1, 8'd5, 8'd2, 8'd4});
    check("t1_count", knn_count, 4);
    wait_done(lat);
    check("t1_done",  done, 1);
    check("t1_class", class_out, 4);

    // 2: equal distances keep arrival order
    pulse_start();
    check("t2_cleared", done, 0);
    strobe(7, 1, 0);
    strobe(7, 2, 0);
    strobe(7, 3, 1);
    check("t2_dist",  knn_dist, {32'd0, 32'd7, 32'd7, 32'd7});
    check("t2_label", knn_label, {8'd0, 8'd3, 8'd2, 8'd1});
    check("t2_count", knn_count, 3);
    wait_done(lat);
    check("t2_class", class_out, 1);

    // 3: majority and vote latency
    pulse_start();
    strobe(4, 1, 0);
    strobe(2, 5, 0);
    strobe(1, 3, 0);
    strobe(3, 5, 1);
    check("t3_label",    knn_label, {8'd1, 8'd5, 8'd5, 8'd3});
    check("t3_done_low", done, 0);
    wait_done(lat);
    check("t3_latency",  lat + 1, 1 + KK);
    check("t3_class",    class_out, 5);

    // 4: single vector, strobes ignored once done
    pulse_start();
    strobe(9, 6, 1);
    wait_done(lat);
    check("t4_count", knn_count, 1);
    check("t4_class", class_out, 6);
    check("t4_done",  done, 1);
    check("t4_ready", m_if.ready, 0);
    strobe(1, 7, 1);
    check("t4_hold_dist",  knn_dist, {96'd0, 32'd9});
    check("t4_hold_label", knn_label, {24'd0, 8'd6});
    check("t4_hold_count", knn_count, 1);
    check("t4_hold_done",  done, 1);

    // 5: restart mid-collect, then async reset mid-vote
    pulse_start();
    strobe(5, 1, 0);
    strobe(6, 2, 0);
    check("t5_count2", knn_count, 2);
    pulse_start();
    check("t5_count0", knn_count, 0);
    check("t5_dist0",  knn_dist, 0);
    check("t5_label0", knn_label, 0);
    check("t5_done0",  done, 0);
    strobe(3, 3, 1);
    @(negedge clk);
    check("t5_pre_rst", knn_count, 1);
    #1 rst = 1'b1;
    #1;
    check("t5_rst_count", knn_count, 0);
    check("t5_rst_dist",  knn_dist, 0);
    check("t5_rst_label", knn_label, 0);
    check("t5_rst_done",  done, 0);
    check("t5_rst_ready", m_if.ready, 0);
    check("t5_rst_class", class_out, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t5_idle_ready", m_if.ready, 0);

    // 6: full-list reject at the boundary distance
    pulse_start();
    strobe(10, 1, 0);
    strobe(20, 2, 0);
    strobe(30, 3, 0);
    strobe(40, 4, 0);
    strobe(40, 9, 0);
    check("t6_rej_dist",  knn_dist, {32'd40, 32'd30, 32'd20, 32'd10});
    check("t6_rej_label", knn_label, {8'd4, 8'd3, 8'd2, 8'd1});
    check("t6_rej_count", knn_count, 4);
    strobe(39, 9, 0);
    check("t6_ins_dist",  knn_dist, {32'd39, 32'd30, 32'd20, 32'd10});
    check("t6_ins_label", knn_label, {8'd9, 8'd3, 8'd2, 8'd1});

    // start beats a simultaneous strobe
    m_if.start      = 1'b1;
    m_if.dist_valid = 1'b1;
    m_if.dist_in    = 32'd1;
    m_if.label_in   = 8'd1;
    @(negedge clk);
    m_if.start      = 1'b0;
    m_if.dist_valid = 1'b0;
    check("t6_start_prio_count", knn_count, 0);
    check("t6_start_prio_dist",  knn_dist, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
